// File: rtl/world_map_arbiter_if.sv
// Bundle of video, bot and map-RAM signals shared between the arbiter and its clients.
interface world_map_arbiter_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 2
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_on_in;
  logic [DATA_W-1:0] vid_world;
  logic              vid_valid;
  logic              vid_on_out;
  logic              bot_req;
  logic [ADDR_W-1:0] bot_addr;
  logic              bot_ack;
  logic [DATA_W-1:0] bot_data;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              bot_starve;
  logic              starve_clr;

  // master: video/bot requesters plus the RAM data return; slave: the arbiter
  modport master (
    output vid_req, vid_addr, vid_on_in, bot_req, bot_addr, starve_clr, mem_rdata,
    input  vid_world, vid_valid, vid_on_out, bot_ack, bot_data, mem_en, mem_addr, bot_starve
  );
  modport slave (
    input  vid_req, vid_addr, vid_on_in, bot_req, bot_addr, starve_clr, mem_rdata,
    output vid_world, vid_valid, vid_on_out, bot_ack, bot_data, mem_en, mem_addr, bot_starve
  );
endinterface

// File: rtl/world_map_arbiter.sv
// Arbitrates the world-map RAM read port: video has absolute priority with fixed
// 3-cycle latency; the bot is served via req/ack in video-free cycles.
module world_map_arbiter #(
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned DATA_W       = 2,
  parameter int unsigned STARVE_LIMIT = 64
) (
  input logic                clk,
  input logic                reset_n,
  world_map_arbiter_if.slave bus
);
  localparam int unsigned       CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_BOT} tag_e;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_READ, S_ACK} state_e;

  state_e            state_q, state_d;
  tag_e              tag1_q, tag1_d, tag2_q;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] vid_world_q, bot_data_q;
  logic              vid_valid_q, bot_ack_q;
  logic [2:0]        von_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              starve_q, starve_d;
  logic              grant;

  always_comb begin
    state_d    = state_q;
    tag1_d     = TAG_NONE;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    grant      = 1'b0;
    if (bus.vid_req) begin
      tag1_d     = TAG_VID;
      mem_en_d   = 1'b1;
      mem_addr_d = bus.vid_addr;
    end else if (state_q == S_IDLE && bus.bot_req) begin
      grant      = 1'b1;
      tag1_d     = TAG_BOT;
      mem_en_d   = 1'b1;
      mem_addr_d = bus.bot_addr;
    end
    case (state_q)
      S_IDLE:  if (grant) state_d = S_ISSUE;
      S_ISSUE: state_d = S_READ;
      S_READ:  state_d = S_ACK;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter holds while a bot transaction is in flight; clear has the last word.
  always_comb begin
    cnt_d    = cnt_q;
    starve_d = starve_q;
    if (!bus.bot_req || grant) begin
      cnt_d = '0;
    end else if (state_q == S_IDLE && cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cnt_d == LIMIT) starve_d = 1'b1;
    if (bus.starve_clr) begin
      cnt_d    = '0;
      starve_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      tag1_q      <= TAG_NONE;
      tag2_q      <= TAG_NONE;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      vid_world_q <= '0;
      vid_valid_q <= 1'b0;
      bot_data_q  <= '0;
      bot_ack_q   <= 1'b0;
      von_q       <= '0;
      cnt_q       <= '0;
      starve_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag1_q;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      vid_valid_q <= (tag2_q == TAG_VID);
      bot_ack_q   <= (tag2_q == TAG_BOT);
      if (tag2_q == TAG_VID) vid_world_q <= bus.mem_rdata;
      if (tag2_q == TAG_BOT) bot_data_q  <= bus.mem_rdata;
      von_q       <= {von_q[1:0], bus.vid_on_in};
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
    end
  end

  assign bus.mem_en     = mem_en_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.vid_world  = vid_world_q;
  assign bus.vid_valid  = vid_valid_q;
  assign bus.vid_on_out = von_q[2];
  assign bus.bot_ack    = bot_ack_q;
  assign bus.bot_data   = bot_data_q;
  assign bus.bot_starve = starve_q;
endmodule

// File: tb/tb_world_map_arbiter.sv
// Bench for world_map_arbiter: a map RAM model plus an event-schedule reference model.
module tb_world_map_arbiter;
  localparam int unsigned AW = 14;
  localparam int unsigned DW = 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  world_map_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  world_map_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(64)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  // Synchronous-read RAM: data one cycle after mem_en.
  logic [DW-1:0] map [16384];
  logic [DW-1:0] rdata_q = '0;
  always @(posedge clk) if (bus.mem_en) rdata_q <= map[bus.mem_addr];
  assign bus.mem_rdata = rdata_q;

  int tests = 0;
  int fails = 0;

  // Reference: every accepted request schedules what must appear 1 and 3 cycles later.
  int unsigned cyc = 0;
  int unsigned bot_free = 0;
  int unsigned scnt = 0;
  bit          sflag = 0;
  bit          bot_auto = 0;
  bit          r_en [8];
  logic [AW-1:0] r_addr [8];
  bit          r_vv [8];
  logic [DW-1:0] r_vw [8];
  bit          r_ack [8];
  logic [DW-1:0] r_bd [8];
  bit          r_on [8];
  bit          exp_en, exp_vv, exp_ack, exp_on, exp_starve;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_vw, exp_bd;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    check("mem_en",     16'(bus.mem_en),     16'(exp_en));
    check("mem_addr",   16'(bus.mem_addr),   16'(exp_addr));
    check("vid_valid",  16'(bus.vid_valid),  16'(exp_vv));
    check("vid_world",  16'(bus.vid_world),  16'(exp_vw));
    check("vid_on_out", 16'(bus.vid_on_out), 16'(exp_on));
    check("bot_ack",    16'(bus.bot_ack),    16'(exp_ack));
    check("bot_data",   16'(bus.bot_data),   16'(exp_bd));
    check("bot_starve", 16'(bus.bot_starve), 16'(exp_starve));
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      r_en[i] = 0; r_addr[i] = '0; r_vv[i] = 0; r_vw[i] = '0;
      r_ack[i] = 0; r_bd[i] = '0; r_on[i] = 0;
    end
    exp_en = 0; exp_addr = '0; exp_vv = 0; exp_vw = '0; exp_on = 0;
    exp_ack = 0; exp_bd = '0; exp_starve = 0;
    scnt = 0; sflag = 0; bot_free = cyc;
  endtask

  // Called at a falling edge with this cycle's inputs already driven.
  task automatic tick();
    bit granted;
    int unsigned s0, s1, s3;
    s1 = (cyc + 1) % 8;
    s3 = (cyc + 3) % 8;
    granted = 0;
    if (bus.vid_req) begin
      r_en[s1] = 1; r_addr[s1] = bus.vid_addr;
      r_vv[s3] = 1; r_vw[s3] = map[bus.vid_addr];
    end else if (bus.bot_req && cyc >= bot_free) begin
      granted = 1;
      r_en[s1] = 1; r_addr[s1] = bus.bot_addr;
      r_ack[s3] = 1; r_bd[s3] = map[bus.bot_addr];
      bot_free = cyc + 4;
    end
    if (!bus.bot_req || granted) scnt = 0;
    else if (cyc >= bot_free && scnt < 64) scnt++;
    if (scnt == 64) sflag = 1;
    if (bus.starve_clr) begin scnt = 0; sflag = 0; end
    r_on[s3] = bus.vid_on_in;

    @(posedge clk);
    cyc++;
    @(negedge clk);
    s0 = cyc % 8;
    exp_en = r_en[s0];
    if (r_en[s0]) exp_addr = r_addr[s0];
    exp_vv = r_vv[s0];
    if (r_vv[s0]) exp_vw = r_vw[s0];
    exp_ack = r_ack[s0];
    if (r_ack[s0]) exp_bd = r_bd[s0];
    exp_on = r_on[s0];
    exp_starve = sflag;
    r_en[s0] = 0; r_vv[s0] = 0; r_ack[s0] = 0; r_on[s0] = 0;
    check_all();
    if (bot_auto && exp_ack) bus.bot_req = 1'b0;
  endtask

  task automatic do_reset(input int unsigned n);
    reset_n = 1'b0;
    #1;
    model_clear();
    check_all();
    repeat (n) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_all();
    end
    reset_n = 1'b1;
    bot_free = cyc;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) map[i] = DW'(i);
    map[14'h1234] = 2'b10;
    bus.vid_req = 1'b1; bus.vid_addr = 14'd3; bus.vid_on_in = 1'b1;
    bus.bot_req = 1'b1; bus.bot_addr = 14'h1234; bus.starve_clr = 1'b0;
    reset_n = 1'b0;

    // Reset with both requesters active, then a single video read after release.
    @(negedge clk);
    do_reset(4);
    bus.bot_req = 1'b0; bus.vid_addr = 14'd7;
    tick();
    bus.vid_req = 1'b0;
    repeat (4) tick();

    // Full-rate video stream.
    for (int i = 0; i < 256; i++) begin
      bus.vid_req = 1'b1; bus.vid_addr = AW'(i); bus.vid_on_in = 1'($urandom);
      tick();
    end
    bus.vid_req = 1'b0;
    repeat (3) tick();

    // Bot served in the gaps of a 1-in-4 video pattern.
    bot_auto = 1;
    bus.bot_addr = 14'h1234; bus.bot_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.vid_req = (i % 4 == 0); bus.vid_addr = AW'($urandom);
      tick();
    end

    // Same-cycle contention: video first, bot next free cycle.
    bus.vid_req = 1'b1; bus.vid_addr = 14'h0ABC;
    bus.bot_req = 1'b1; bus.bot_addr = 14'h0123;
    tick();
    bus.vid_req = 1'b0;
    repeat (6) tick();

    // Starvation under continuous video, sticky after video stops, then cleared.
    bus.bot_req = 1'b1; bus.bot_addr = 14'h1234;
    for (int i = 0; i < 70; i++) begin
      bus.vid_req = 1'b1; bus.vid_addr = AW'($urandom);
      tick();
    end
    bus.vid_req = 1'b0;
    repeat (6) tick();
    check("starve_sticky", 16'(bus.bot_starve), 16'd1);
    bus.starve_clr = 1'b1;
    tick();
    bus.starve_clr = 1'b0;
    tick();

    // Reset while the bot read is in flight; the held request reissues afterwards.
    bus.bot_req = 1'b1; bus.bot_addr = 14'h1234;
    tick();
    tick();
    do_reset(2);
    repeat (6) tick();

    // Randomised traffic with a scrambled map.
    for (int i = 256; i < 16384; i++) map[i] = DW'($urandom);
    for (int k = 0; k < 2000; k++) begin
      bus.vid_req = (k < 500) ? ($urandom_range(0, 99) < 95) : ($urandom_range(0, 99) < 40);
      bus.vid_addr = AW'($urandom);
      bus.vid_on_in = 1'($urandom);
      if (!bus.bot_req && $urandom_range(0, 3) == 0) begin
        bus.bot_req = 1'b1; bus.bot_addr = AW'($urandom);
      end else if (bus.bot_req && $urandom_range(0, 19) == 0) begin
        bus.bot_req = 1'b0;
      end
      bus.starve_clr = ($urandom_range(0, 49) == 0);
      if (k == 1000) do_reset(2);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
